// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory, the redirect source and decode.
// The master modport is the fetch unit's side of the bundle.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_misaligned;
    logic        if_ready;

    modport master (
        input  redirect_valid, redirect_addr,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_pc, if_inst, if_misaligned,
        input  if_ready
    );

    modport slave (
        output redirect_valid, redirect_addr,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_pc, if_inst, if_misaligned,
        output if_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter owner: issues one instruction fetch at a time, holds the result for decode,
// and lets redirects kill held slots or in-flight requests.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        HOLD,
        DROP,
        FAULT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        if_valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_inst_q;
    logic        if_mis_q;
    logic        req_valid;
    logic        req_fire;

    // Request is gated by rst_n so nothing is issued while reset is held low.
    assign req_valid = rst_n && (state_q == REQ) && (pc_q[1:0] == 2'b00);
    assign req_fire  = req_valid && bus.imem_req_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_inst        = if_inst_q;
    assign bus.if_misaligned  = if_mis_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_mis_q   <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_q       <= bus.redirect_addr;
            if_valid_q <= 1'b0;
            if_mis_q   <= 1'b0;
            // An accepted or outstanding request must still be drained before fetching again.
            case (state_q)
                REQ:        state_q <= req_fire ? DROP : REQ;
                WAIT, DROP: state_q <= bus.imem_rsp_valid ? REQ : DROP;
                default:    state_q <= REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (pc_q[1:0] != 2'b00) begin
                        if_valid_q <= 1'b1;
                        if_pc_q    <= pc_q;
                        if_inst_q  <= NOP_INST;
                        if_mis_q   <= 1'b1;
                        state_q    <= HOLD;
                    end else if (bus.imem_req_ready) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if_valid_q <= 1'b1;
                        if_pc_q    <= pc_q;
                        if_inst_q  <= bus.imem_rsp_data;
                        if_mis_q   <= 1'b0;
                        pc_q       <= pc_q + 32'd4;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (if_valid_q && bus.if_ready) begin
                        if_valid_q <= 1'b0;
                        if_mis_q   <= 1'b0;
                        state_q    <= if_mis_q ? FAULT : REQ;
                    end
                end
                DROP: begin
                    if (bus.imem_rsp_valid) begin
                        state_q <= REQ;
                    end
                end
                FAULT:   state_q <= FAULT;
                default: state_q <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors for reset and streaming,
// then hand-written sequences for stalls, redirects, misaligned faults, wrap and mid-run reset.
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        ifr;
        logic        reqv;
        logic [31:0] addr;
        logic        ifv;
        logic [31:0] ipc;
        logic [31:0] inst;
        logic        mis;
    } vec_t;

    vec_t vecs[13];

    // Drives one cycle of inputs just after the falling edge; outputs are then settled for checking.
    task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] ra,
                                 input logic rdy, input logic rspv, input logic [31:0] rspd,
                                 input logic ifr);
        @(negedge clk);
        rst_n              = rst;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rspv;
        bus.imem_rsp_data  = rspd;
        bus.if_ready       = ifr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkReq(input string tag, input logic reqv, input logic [31:0] addr);
        checkOutput({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, {31'd0, reqv});
        checkOutput({tag, ".req_addr"}, bus.imem_req_addr, addr);
    endtask

    task automatic checkSlot(input string tag, input logic ifv, input logic [31:0] ipc,
                             input logic [31:0] inst, input logic mis);
        checkOutput({tag, ".if_valid"}, {31'd0, bus.if_valid}, {31'd0, ifv});
        checkOutput({tag, ".if_pc"}, bus.if_pc, ipc);
        checkOutput({tag, ".if_inst"}, bus.if_inst, inst);
        checkOutput({tag, ".if_mis"}, {31'd0, bus.if_misaligned}, {31'd0, mis});
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        // rst, rdy, rspv, rspd, ifr | reqv, addr, ifv, ipc, inst, mis
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'hA5A5_0000, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h04, 1'b1, 32'h0, 32'hA5A5_0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'hA5A5_0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'hA5A5_0004, 1'b1, 1'b0, 32'h04, 1'b0, 32'h0, 32'hA5A5_0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h4, 32'hA5A5_0004, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h4, 32'hA5A5_0004, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'hA5A5_0008, 1'b1, 1'b0, 32'h08, 1'b0, 32'h4, 32'hA5A5_0004, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h8, 32'hA5A5_0008, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h8, 32'hA5A5_0008, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 32'hA5A5_000C, 1'b1, 1'b0, 32'h0C, 1'b0, 32'h8, 32'hA5A5_0008, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 32'hC, 32'hA5A5_000C, 1'b0};

        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b0;
        #1;
        checkOutput("pre_edge.req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        @(posedge clk);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rst, 1'b0, 32'h0, vecs[i].rdy, vecs[i].rspv, vecs[i].rspd, vecs[i].ifr);
            checkReq($sformatf("stream%0d", i), vecs[i].reqv, vecs[i].addr);
            checkSlot($sformatf("stream%0d", i), vecs[i].ifv, vecs[i].ipc, vecs[i].inst, vecs[i].mis);
        end

        // Decode stall at pc 0x10.
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkReq("stall_req", 1, 32'h10);
        applyStimulus(1, 0, 0, 1, 1, 32'hA5A5_0010, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 0, 0);
            checkReq($sformatf("stall%0d", i), 0, 32'h14);
            checkSlot($sformatf("stall%0d", i), 1, 32'h10, 32'hA5A5_0010, 0);
        end
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkReq("stall_release", 0, 32'h14);
        checkSlot("stall_release", 1, 32'h10, 32'hA5A5_0010, 0);
        applyStimulus(1, 1, 32'h20, 0, 0, 0, 1);
        checkReq("after_release", 1, 32'h14);
        checkSlot("after_release", 0, 32'h10, 32'hA5A5_0010, 0);

        // Redirect during WAIT with a response three cycles after acceptance.
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkReq("wait_req20", 1, 32'h20);
        applyStimulus(1, 1, 32'h100, 0, 0, 0, 1);
        checkReq("wait_redir", 0, 32'h20);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkReq("drop_idle", 0, 32'h100);
        applyStimulus(1, 0, 0, 1, 1, 32'hDEAD_0020, 1);
        checkReq("drop_rsp", 0, 32'h100);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkReq("req100", 1, 32'h100);
        checkOutput("req100.if_valid", {31'd0, bus.if_valid}, 32'd0);
        applyStimulus(1, 0, 0, 1, 1, 32'hA5A5_0100, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkSlot("slot100", 1, 32'h100, 32'hA5A5_0100, 0);

        // Redirect in the same cycle the request is accepted, then redirect during HOLD with if_ready.
        applyStimulus(1, 1, 32'h40, 1, 0, 0, 1);
        checkReq("redir_accept", 1, 32'h104);
        applyStimulus(1, 0, 0, 1, 1, 32'hDEAD_0104, 1);
        checkReq("stale_drop", 0, 32'h40);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkReq("req40", 1, 32'h40);
        applyStimulus(1, 0, 0, 1, 1, 32'hA5A5_0040, 1);
        applyStimulus(1, 1, 32'h80, 1, 0, 0, 1);
        checkSlot("slot40", 1, 32'h40, 32'hA5A5_0040, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkOutput("killed.if_valid", {31'd0, bus.if_valid}, 32'd0);
        checkReq("req80", 1, 32'h80);
        applyStimulus(1, 0, 0, 1, 1, 32'hA5A5_0080, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkSlot("slot80", 1, 32'h80, 32'hA5A5_0080, 0);

        // Misaligned redirect: fault slot, then idle until the next redirect.
        applyStimulus(1, 1, 32'h102, 0, 0, 0, 1);
        checkReq("pre_mis", 1, 32'h84);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkReq("mis_noreq", 0, 32'h102);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkReq("mis_hold", 0, 32'h102);
        checkSlot("mis_hold", 1, 32'h102, 32'h0000_0013, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkSlot("mis_consume", 1, 32'h102, 32'h0000_0013, 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 0, 1, 1, 32'hBAD0_0000, 1);
            checkReq($sformatf("fault%0d", i), 0, 32'h102);
            checkOutput($sformatf("fault%0d.if_valid", i), {31'd0, bus.if_valid}, 32'd0);
            checkOutput($sformatf("fault%0d.if_mis", i), {31'd0, bus.if_misaligned}, 32'd0);
        end
        applyStimulus(1, 1, 32'h200, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkReq("req200", 1, 32'h200);
        applyStimulus(1, 0, 0, 1, 1, 32'hA5A5_0200, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkSlot("slot200", 1, 32'h200, 32'hA5A5_0200, 0);

        // PC wrap from 0xFFFF_FFFC.
        applyStimulus(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkReq("req_top", 1, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 1, 1, 32'h5A5A_FFFC, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkSlot("slot_top", 1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 0);
        checkReq("wrap_addr", 0, 32'h0);
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        checkReq("req_wrap", 1, 32'h0);

        // Reset while in WAIT, response arrives the cycle after.
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkReq("mid_reset", 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        checkReq("post_reset", 1, 32'h0);
        checkSlot("post_reset", 0, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkReq("post_rsp", 1, 32'h0);
        checkSlot("post_rsp", 0, 32'h0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the program counter and fetches instructions from instruction memory over a valid/ready request plus response-valid interface.
- Holds one fetched instruction for decode.
- Accepts redirects from the jump/branch target stage (`redirect_addr` carries its computed target) and kills in-flight or held fetches.
- Sits between the jump target stage / instruction memory (upstream) and decode (downstream).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word presented with a misalignment fault (addi x0,x0,0).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- redirect_valid  input  1  load new PC this cycle
- redirect_addr  input  32  new PC (jump/branch target)
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  32  fetch address (= current PC)
- imem_req_ready  input  1  memory accepts request
- imem_rsp_valid  input  1  one-cycle response strobe
- imem_rsp_data  input  32  instruction word
- if_valid  output  1  instruction held for decode
- if_pc  output  32  PC of held instruction
- if_inst  output  32  held instruction
- if_misaligned  output  1  held slot is a misaligned-fetch fault
- if_ready  input  1  decode consumes held slot

Behaviour:
- All state is registered on the rising edge of clk.
- rst_n=0 at an edge, regardless of state, produces:
  - pc=RESET_PC, state=REQ.
  - if_valid=0, if_pc=0, if_inst=0, if_misaligned=0.
  - imem_req_valid=0 while rst_n=0.
  - Any response arriving after reset is ignored.
- States: REQ, WAIT, HOLD, DROP, FAULT. imem_req_valid=1 only in REQ with pc[1:0]==0. imem_req_addr=pc always.
- At most one outstanding memory request.
- REQ:
  - pc[1:0]!=0: no request. Next cycle: if_valid=1, if_pc=pc, if_inst=NOP_INST, if_misaligned=1, state HOLD, fault flag set.
  - Otherwise, on imem_req_ready=1: to WAIT.
- WAIT: on imem_rsp_valid=1, the next cycle gives:
  - if_valid=1, if_pc=pc, if_inst=imem_rsp_data, if_misaligned=0.
  - pc=pc+4, mod 2^32, so 32'hFFFF_FFFC wraps to 0.
  - state HOLD.
- HOLD: on if_valid & if_ready: if_valid=0, if_misaligned=0. Go to FAULT if the slot was a fault, else REQ. if_pc and if_inst hold their values while if_valid=1.
- FAULT: no requests, no output. Only redirect leaves it.
- DROP: waits for imem_rsp_valid, discards the data, goes to REQ.
- Latency: request accepted at cycle N, response at N+k, if_valid at N+k+1. Minimum 2 cycles from an accepted request to if_valid. Next request no earlier than the cycle after consumption.
- redirect_valid=1 has priority over every other event:
  - In all states, pc<=redirect_addr and if_valid<=0, killing any held slot even when if_ready=1 that cycle.
  - REQ without imem_req_ready: to REQ.
  - REQ with imem_req_ready=1 the same cycle: the stale request was accepted, so to DROP.
  - WAIT with imem_rsp_valid=1 the same cycle: response discarded, to REQ.
  - WAIT without imem_rsp_valid: to DROP.
  - HOLD or FAULT: to REQ.
  - DROP with imem_rsp_valid=1 the same cycle: to REQ.
  - DROP without imem_rsp_valid: stays DROP.
- imem_rsp_valid outside WAIT/DROP is ignored.

Test Plan:
- Reset then stream:
  - Stimulus: rst_n low 2 cycles, RESET_PC=0. Memory always ready, 1-cycle response, data=addr^32'hA5A5_0000. if_ready=1.
  - Required: if_pc sequence 0,4,8,C with matching if_inst. imem_req_valid=0 during reset.
- Decode stall:
  - Stimulus: hold if_ready=0 for 5 cycles after if_valid at pc=0x10.
  - Required: if_pc/if_inst stable. No new imem_req_valid until the cycle after if_ready=1.
- Redirect during WAIT:
  - Stimulus: request for 0x20 accepted, response delayed 3 cycles, redirect to 0x100 one cycle after acceptance.
  - Required: the response for 0x20 is dropped. The next request address is 0x100. First if_pc=0x100.
- Redirect with simultaneous events:
  - Stimulus 1: redirect to 0x40 in the same cycle as imem_req_ready. Required: stale response dropped, next request 0x40.
  - Stimulus 2: redirect to 0x80 in HOLD with if_ready=1. Required: held slot killed, next if_pc=0x80.
- Misaligned redirect:
  - Stimulus: redirect_addr=0x0000_0102.
  - Required: no imem request. if_valid=1, if_pc=0x102, if_inst=0x0000_0013, if_misaligned=1. After consumption, idle in FAULT. A later redirect to 0x200 resumes fetch at 0x200.
- Wrap and mid-operation reset:
  - Stimulus 1: redirect to 0xFFFF_FFFC. Required: the following fetch is at 0x0000_0000.
  - Stimulus 2: assert rst_n=0 in WAIT with a response arriving the next cycle. Required: response ignored, if_valid=0, first request at RESET_PC.
